// File: rtl/seq_left_shifter_pkg.sv
// Shared definitions for the shifter family: default widths and the FSM
// state encoding used by both the left and right shifters.
package seq_left_shifter_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int SHW_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_left_shifter_step.sv
// Combinational one-position left shift (mode=0, zero fill) or rotate
// (mode=1, MSB wraps into bit 0). Kept separate so a barrel version can stack it.
module shl_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] din,
    input  logic             mode,
    output logic [WIDTH-1:0] dout
);

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_bit
            assign dout[gi] = din[gi-1];
        end
    endgenerate

    assign dout[0] = mode & din[WIDTH-1];

endmodule

// File: rtl/seq_left_shifter.sv
// Iterative left shifter/rotator: one bit position per clock, done pulse on
// completion. Top level holds only the FSM and its registers.
module seq_left_shifter
    import seq_left_shifter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SHW   = SHW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num,
    input  logic [SHW-1:0]   shift,
    input  logic             mode,
    output logic [WIDTH-1:0] ans,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ans_q, ans_d;
    logic [SHW-1:0]   count_q, count_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] step_ans;

    shl_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .din  (ans_q),
        .mode (mode_q),
        .dout (step_ans)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ans_q   <= '0;
            count_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ans_q   <= ans_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ans_d   = ans_q;
        count_d = count_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ans_d   = num;
                    count_d = shift;
                    mode_d  = mode;
                    // A zero shift skips SHIFT so count never starts at 0 there.
                    state_d = (shift != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                ans_d   = step_ans;
                count_d = count_q - SHW'(1);
                if (count_q == SHW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registered state, so no input reaches them combinationally.
    assign ans  = ans_q;
    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_left_shifter.sv
// Self-checking bench for seq_left_shifter: vector table plus hand-written
// multi-cycle sequences, with a done-driven scoreboard.
module tb_seq_left_shifter;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] num;
    logic [S-1:0] shift;
    logic         mode;
    logic [W-1:0] ans;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    seq_left_shifter #(
        .WIDTH (W),
        .SHW   (S)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .num   (num),
        .shift (shift),
        .mode  (mode),
        .ans   (ans),
        .busy  (busy),
        .done  (done)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] ans;
        int           lat;
        int           acc;
    } sb_t;

    typedef struct {
        logic [W-1:0] num;
        logic [S-1:0] shift;
        logic         mode;
        logic [W-1:0] exp_ans;
    } vec_t;

    sb_t sb_q[$];
    sb_t sb_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: each done pulse retires the oldest accepted request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                sb_e = sb_q.pop_front();
                chk("done_ans", 32'(ans), 32'(sb_e.ans));
                chk("done_latency", 32'(cyc - sb_e.acc), 32'(sb_e.lat));
                $display("op done: ans=0x%02h expected=0x%02h latency=%0d", ans, sb_e.ans, cyc - sb_e.acc);
            end
        end
    end

    task automatic do_op(input logic [W-1:0] n, input logic [S-1:0] s, input logic m,
                         input logic [W-1:0] exp, input bit junk);
        int  busy_cnt;
        bit  seen;
        sb_t e;
        busy_cnt = 0;
        seen     = 1'b0;
        @(negedge clk);
        start = 1'b1;
        num   = n;
        shift = s;
        mode  = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.ans = exp;
        e.lat = int'(s);
        e.acc = cyc;
        sb_q.push_back(e);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) seen = 1'b1;
            if (junk) begin
                start = 1'b1;
                num   = ~n;
                shift = S'($urandom_range(0, 7));
                mode  = ~m;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done within 40 cycles, expected one (num=0x%02h shift=%0d)", n, s);
            sb_q.delete();
        end
        chk("busy_cycles", 32'(busy_cnt), 32'(int'(s) + 1));
        @(negedge clk);
        start = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
        chk("ans_hold", 32'(ans), 32'(exp));
    endtask

    vec_t vecs[10];

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h81, 3'd1, 1'b0, 8'h02};
        vecs[1] = '{8'h81, 3'd3, 1'b1, 8'h0C};
        vecs[2] = '{8'hA5, 3'd0, 1'b0, 8'hA5};
        vecs[3] = '{8'hA5, 3'd0, 1'b1, 8'hA5};
        vecs[4] = '{8'hFF, 3'd7, 1'b0, 8'h80};
        vecs[5] = '{8'hFF, 3'd7, 1'b1, 8'hFF};
        vecs[6] = '{8'h5A, 3'd4, 1'b0, 8'hA0};
        vecs[7] = '{8'h96, 3'd2, 1'b1, 8'h5A};
        vecs[8] = '{8'h01, 3'd7, 1'b1, 8'h80};
        vecs[9] = '{8'hC1, 3'd6, 1'b0, 8'h40};

        rst   = 1'b1;
        start = 1'b0;
        num   = '0;
        shift = '0;
        mode  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ans", 32'(ans), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].num, vecs[i].shift, vecs[i].mode, vecs[i].exp_ans, 1'b0);
        end

        // Rotate-by-3 trace: ans must walk through each intermediate step.
        @(negedge clk);
        start = 1'b1;
        num   = 8'h81;
        shift = 3'd3;
        mode  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sb_e.ans = 8'h0C;
        sb_e.lat = 3;
        sb_e.acc = cyc;
        sb_q.push_back(sb_e);
        @(negedge clk);
        chk("trace_load", 32'(ans), 32'h81);
        chk("trace_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("trace_step1", 32'(ans), 32'h03);
        @(negedge clk);
        chk("trace_step2", 32'(ans), 32'h06);
        @(negedge clk);
        chk("trace_step3", 32'(ans), 32'h0C);
        chk("trace_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("trace_idle", 32'(busy), 32'd0);

        // Starts during SHIFT and DONE must be ignored.
        do_op(8'h3C, 3'd4, 1'b1, 8'hC3, 1'b1);
        do_op(8'h5A, 3'd0, 1'b1, 8'h5A, 1'b1);

        // Reset in the second SHIFT cycle of a shift=5 request.
        @(negedge clk);
        start = 1'b1;
        num   = 8'hB7;
        shift = 3'd5;
        mode  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("rst_pre_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ans", 32'(ans), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        repeat (8) @(negedge clk);
        chk("rst_stays_idle", 32'(busy), 32'd0);

        do_op(8'h3C, 3'd5, 1'b0, 8'h80, 1'b0);
        do_op(8'h3C, 3'd5, 1'b1, 8'h87, 1'b0);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
